// File: rtl/tb_uart.sv
// tb_uart: simulation-side 8N1 UART transceiver for the chip bench.
//   Receives what the firmware sends on the chip's UART TX pin (ser_rx).
//   Drives serial data into the chip's UART RX pin (ser_tx).
//   TX uses a level-triggered start with a clear-request handshake.
//
// Parameters:
//   BAUD_DIV      clock cycles per bit (4..65535)
//
// Ports:
//   clock         system clock
//   resetb        asynchronous active-low reset
//   ser_rx        serial input, idle high
//   ser_tx        serial output, idle high
//   tx_start      level request to send tx_data
//   tx_data       byte to send, captured when a frame starts
//   tx_busy       high during start/data/stop bits
//   tx_clear_req  high after a frame until tx_start is seen low
//   rx_data       last received byte
//   rx_valid      one-cycle pulse on a good stop bit
//   rx_frame_err  one-cycle pulse on a low stop bit
module tb_uart #(
    parameter int BAUD_DIV = 4167
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_bit_end;
    logic        tx_load;
    logic        tx_adv;

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_load    = (tx_state == TX_IDLE) && tx_start && !tx_clear_req;
    // The shift register steps whenever the next data bit is put on the line.
    assign tx_adv     = ((tx_state == TX_START) || (tx_state == TX_DATA)) && tx_bit_end;

    always_ff @(posedge clock) begin
        if (tx_load) begin
            tx_shift <= tx_data;
        end else if (tx_adv) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    ser_tx <= 1'b1;
                    if (tx_load) begin
                        tx_state <= TX_START;
                        tx_cnt   <= '0;
                        ser_tx   <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        ser_tx   <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            ser_tx   <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            ser_tx <= tx_shift[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_state     <= TX_DONE;
                        tx_cnt       <= '0;
                        tx_busy      <= 1'b0;
                        tx_clear_req <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DONE: begin
                    // Waiting here is what keeps a held tx_start from resending.
                    if (!tx_start) begin
                        tx_state     <= TX_IDLE;
                        tx_clear_req <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    ser_tx   <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t   rx_state;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_q;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= ser_rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    always_ff @(posedge clock) begin
        if ((rx_state == RX_DATA) && (rx_cnt == BIT_LAST)) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    // The edge is seen one cycle after it reaches rx_s2, so the
                    // counter starts at 1 to keep the mid-bit sample centred.
                    if (rx_q && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt       <= '0;
                        rx_state     <= RX_IDLE;
                        rx_data      <= rx_shift;
                        rx_valid     <= rx_s2;
                        rx_frame_err <= !rx_s2;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rx_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb_uart.sv
// tb_tb_uart: directed self-checking bench for tb_uart at BAUD_DIV=16.
module tb_tb_uart;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       ser_rx_drv = 1'b1;
    logic       loopback = 1'b0;
    logic       ser_rx_w;
    logic       ser_tx;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    int checks = 0;
    int errors = 0;

    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] rx_log [0:15];

    assign ser_rx_w = loopback ? ser_tx : ser_rx_drv;

    tb_uart #(.BAUD_DIV(16)) dut (
        .clock        (clk),
        .resetb       (resetb),
        .ser_rx       (ser_rx_w),
        .ser_tx       (ser_tx),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_clear_req (tx_clear_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    // Receive event log, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log[valid_cnt[3:0]] <= rx_data;
            valid_cnt <= valid_cnt + 1;
        end
        if (rx_frame_err === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
        end
    end

    // Drive one serial frame on ser_rx; even slots last len_a cycles, odd slots len_b.
    task automatic rx_frame(input logic [7:0] d, input logic stop, input int len_a, input int len_b);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int s = 0; s < 10; s++) begin
            ser_rx_drv = f[s];
            repeat ((s % 2 == 0) ? len_a : len_b) @(negedge clk);
        end
        ser_rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        checks++; if (tx_clear_req !== 1'b0) begin errors++; $display("FAIL reset_clear_req: got %b expected 0", tx_clear_req); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
        resetb = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx();
        logic [9:0] exp_bits;
        logic       extra;
        exp_bits = 10'b1001100000;   // 0x30 framed, LSB on the line first
        extra = 1'b0;
        @(negedge clk);
        tx_data  = 8'h30;
        tx_start = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_rise: got %b expected 1", tx_busy); end
        checks++; if (ser_tx !== 1'b0) begin errors++; $display("FAIL tx_start_bit: got %b expected 0", ser_tx); end
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 40) tx_data = 8'hFF;
            if ((c % 16 == 8) && (c < 160)) begin
                checks++;
                if (ser_tx !== exp_bits[c / 16]) begin
                    errors++;
                    $display("FAIL tx_bit%0d: got %b expected %b", c / 16, ser_tx, exp_bits[c / 16]);
                end
            end
            if (c == 159) begin
                checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_159: got %b expected 1", tx_busy); end
            end
            if (c == 160) begin
                checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_160: got %b expected 0", tx_busy); end
                checks++; if (tx_clear_req !== 1'b1) begin errors++; $display("FAIL tx_clear_160: got %b expected 1", tx_clear_req); end
            end
            if ((c > 160) && ((tx_busy !== 1'b0) || (ser_tx !== 1'b1))) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL tx_no_resend: got %b expected 0", extra); end
        checks++; if (tx_clear_req !== 1'b1) begin errors++; $display("FAIL tx_clear_held: got %b expected 1", tx_clear_req); end
        @(negedge clk);
        tx_start = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx_clear_req !== 1'b0) begin errors++; $display("FAIL tx_clear_drop: got %b expected 0", tx_clear_req); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rx();
        int la [3];
        int lb [3];
        int vb;
        int fb;
        la = '{16, 15, 17};
        lb = '{16, 17, 15};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            vb = valid_cnt;
            fb = ferr_cnt;
            rx_frame(8'h41, 1'b1, la[v], lb[v]);
            repeat (20) @(negedge clk);
            checks++; if (valid_cnt - vb != 1) begin errors++; $display("FAIL rx_valid_count_v%0d: got %0d expected 1", v, valid_cnt - vb); end
            checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL rx_data_v%0d: got %h expected 41", v, rx_data); end
            checks++; if (ferr_cnt - fb != 0) begin errors++; $display("FAIL rx_no_ferr_v%0d: got %0d expected 0", v, ferr_cnt - fb); end
        end
    endtask

    task automatic test_glitch();
        int vb;
        int fb;
        @(negedge clk);
        vb = valid_cnt;
        fb = ferr_cnt;
        ser_rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (valid_cnt - vb != 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - vb); end
        checks++; if (ferr_cnt - fb != 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - fb); end
        // A real frame right after the glitch must still be received.
        rx_frame(8'h5A, 1'b1, 16, 16);
        repeat (20) @(negedge clk);
        checks++; if (valid_cnt - vb != 1) begin errors++; $display("FAIL glitch_then_frame: got %0d expected 1", valid_cnt - vb); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_then_data: got %h expected 5a", rx_data); end
    endtask

    task automatic test_frame_err();
        int vb;
        int fb;
        @(negedge clk);
        vb = valid_cnt;
        fb = ferr_cnt;
        rx_frame(8'h61, 1'b0, 16, 16);
        repeat (30) @(negedge clk);
        checks++; if (ferr_cnt - fb != 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt - fb); end
        checks++; if (valid_cnt - vb != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - vb); end
        checks++; if (rx_data !== 8'h61) begin errors++; $display("FAIL ferr_data: got %h expected 61", rx_data); end
    endtask

    task automatic test_back_to_back();
        int         vb;
        int         n;
        logic [7:0] bytes [2];
        logic [3:0] i0;
        logic [3:0] i1;
        bytes = '{8'h0F, 8'h3D};
        @(negedge clk);
        loopback = 1'b1;
        repeat (4) @(negedge clk);
        vb = valid_cnt;
        for (int k = 0; k < 2; k++) begin
            tx_data  = bytes[k];
            tx_start = 1'b1;
            n = 0;
            while ((tx_clear_req !== 1'b1) && (n < 400)) begin @(negedge clk); n++; end
            checks++; if (tx_clear_req !== 1'b1) begin errors++; $display("FAIL loop_done%0d: got %b expected 1 within 400 cycles", k, tx_clear_req); end
            tx_start = 1'b0;
            n = 0;
            while ((tx_clear_req !== 1'b0) && (n < 10)) begin @(negedge clk); n++; end
        end
        repeat (30) @(negedge clk);
        i0 = 4'(vb);
        i1 = 4'(vb + 1);
        checks++; if (valid_cnt - vb != 2) begin errors++; $display("FAIL loop_count: got %0d expected 2", valid_cnt - vb); end
        checks++; if (rx_log[i0] !== 8'h0F) begin errors++; $display("FAIL loop_byte0: got %h expected 0f", rx_log[i0]); end
        checks++; if (rx_log[i1] !== 8'h3D) begin errors++; $display("FAIL loop_byte1: got %h expected 3d", rx_log[i1]); end
        loopback = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic [9:0] exp_bits;
        exp_bits = 10'b1001111000;   // 0x3C framed, LSB on the line first
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
        end
        // Now inside data bit 3 of 0xA5, which is 0.
        checks++; if (ser_tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b expected 0", ser_tx); end
        #3;
        resetb = 1'b0;
        #1;
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_ser_tx: got %b expected 1", ser_tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", tx_busy); end
        @(negedge clk);
        tx_start = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (2) @(negedge clk);
        // Single-cycle start request.
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL after_busy: got %b expected 1", tx_busy); end
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 1; c <= 162; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            else begin @(posedge clk); #1; end
            if ((c % 16 == 8) && (c < 160)) begin
                checks++;
                if (ser_tx !== exp_bits[c / 16]) begin
                    errors++;
                    $display("FAIL after_bit%0d: got %b expected %b", c / 16, ser_tx, exp_bits[c / 16]);
                end
            end
            if (c == 160) begin
                checks++; if ((tx_busy !== 1'b0) || (tx_clear_req !== 1'b1)) begin errors++; $display("FAIL after_done: got busy=%b clr=%b expected busy=0 clr=1", tx_busy, tx_clear_req); end
            end
            if (c == 161) begin
                checks++; if (tx_clear_req !== 1'b0) begin errors++; $display("FAIL after_clear: got %b expected 0", tx_clear_req); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
